// File: rtl/multi_channel_watchdog_if.sv
// Control/status bundle between the verification top and the watchdog.
interface multi_channel_watchdog_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 24,
  parameter int GLB_W    = 32
);
  logic                start;
  logic                kick;
  logic                done_req;
  logic [CHANNELS-1:0] line;
  logic [CHANNELS-1:0] enable;
  logic [CNT_W-1:0]    idle_limit;
  logic [GLB_W-1:0]    global_limit;
  logic [2:0]          state;
  logic                busy;
  logic                done_ack;
  logic                timeout;
  logic [CHANNELS-1:0] chan_timeout;
  logic [3:0]          first_chan;
  logic                global_expired;

  modport master (
    output start, kick, done_req, line, enable, idle_limit, global_limit,
    input  state, busy, done_ack, timeout, chan_timeout, first_chan, global_expired
  );

  modport slave (
    input  start, kick, done_req, line, enable, idle_limit, global_limit,
    output state, busy, done_ack, timeout, chan_timeout, first_chan, global_expired
  );
endinterface

// File: rtl/multi_channel_watchdog.sv
// Watchdog over CHANNELS serial lines plus a global run timer, with a
// done_req/done_ack drain handshake. TIMEOUT is terminal until rst_n.

module mcw_chan #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_i,
  input  logic             en_i,
  input  logic             active_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tog_o,
  output logic             expire_o
);
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tog_o    = sync_q[1] ^ sync_q[2];
  assign expire_o = active_i && en_i && !tog_o && (limit_i != '0) &&
                    (cnt_q == limit_i - CNT_W'(1));

  always_comb begin
    sync_d = {sync_q[1:0], line_i};
    cnt_d  = cnt_q;
    if (tog_o || !en_i || !active_i) cnt_d = '0;
    else if (cnt_q != limit_i)       cnt_d = cnt_q + CNT_W'(1);
  end

  // Sync chain resets to the serial idle level so reset release is edge-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module multi_channel_watchdog #(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 24,
  parameter int GLB_W        = 32,
  parameter int DRAIN_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  multi_channel_watchdog_if.slave bus
);
  localparam int QW = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [GLB_W-1:0]    gcnt_q, gcnt_d;
  logic [QW-1:0]       qcnt_q, qcnt_d;
  logic [CHANNELS-1:0] chan_to_q, chan_to_d;
  logic [3:0]          first_q, first_d;
  logic                gexp_q, gexp_d;
  logic                busy_q, busy_d;
  logic                done_ack_q, done_ack_d;
  logic                timeout_q, timeout_d;

  logic [CHANNELS-1:0] tog, chan_exp;
  logic                active, glb_exp, any_exp, quiet, start_acc;
  logic [3:0]          low_idx;

  assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    mcw_chan #(.CNT_W(CNT_W)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .line_i   (bus.line[i]),
      .en_i     (bus.enable[i]),
      .active_i (active),
      .limit_i  (bus.idle_limit),
      .tog_o    (tog[i]),
      .expire_o (chan_exp[i])
    );
  end

  always_comb begin
    glb_exp   = active && !bus.kick && (bus.global_limit != '0) &&
                (gcnt_q == bus.global_limit - GLB_W'(1));
    any_exp   = (|chan_exp) || glb_exp;
    quiet     = ~|(tog & bus.enable);
    start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    low_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (chan_exp[i]) low_idx = 4'(i);

    // Expiry outranks both done_req and drain completion.
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (any_exp)           state_d = S_TIMEOUT;
        else if (bus.done_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (any_exp)                                          state_d = S_TIMEOUT;
        else if (!bus.done_req)                               state_d = S_RUN;
        else if (quiet && qcnt_q == QW'(DRAIN_CYCLES - 1))    state_d = S_DONE;
      end
      default: state_d = state_q;
    endcase

    gcnt_d = gcnt_q;
    if (start_acc || bus.kick) gcnt_d = '0;
    else if (active)           gcnt_d = gcnt_q + GLB_W'(1);

    qcnt_d = '0;
    if (state_q == S_DRAIN && state_d == S_DRAIN && quiet) qcnt_d = qcnt_q + QW'(1);

    chan_to_d = start_acc ? '0 : (chan_to_q | chan_exp);
    gexp_d    = start_acc ? 1'b0 : (gexp_q | glb_exp);
    first_d   = start_acc ? 4'd0 : ((|chan_exp) ? low_idx : first_q);

    busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_ack_d = (state_d == S_DONE);
    timeout_d  = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gcnt_q     <= '0;
      qcnt_q     <= '0;
      chan_to_q  <= '0;
      first_q    <= '0;
      gexp_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_ack_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      qcnt_q     <= qcnt_d;
      chan_to_q  <= chan_to_d;
      first_q    <= first_d;
      gexp_q     <= gexp_d;
      busy_q     <= busy_d;
      done_ack_q <= done_ack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.state          = state_q;
  assign bus.busy           = busy_q;
  assign bus.done_ack       = done_ack_q;
  assign bus.timeout        = timeout_q;
  assign bus.chan_timeout   = chan_to_q;
  assign bus.first_chan     = first_q;
  assign bus.global_expired = gexp_q;
endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench: expiry vector table plus hand sequences for reset,
// kick, drain handshake and expiry-vs-drain priority.
module tb_multi_channel_watchdog;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  multi_channel_watchdog_if #(.CHANNELS(4), .CNT_W(24), .GLB_W(32)) bus ();

  multi_channel_watchdog #(
    .CHANNELS(4), .CNT_W(24), .GLB_W(32), .DRAIN_CYCLES(64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] lim;
    logic [31:0] glim;
    logic [3:0]  en;
    logic [3:0]  held;
    int          stop;
    int          exp_step;
    logic [3:0]  exp_chan;
    logic [3:0]  exp_first;
    logic        exp_gexp;
  } vec_t;

  vec_t vt[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.kick         = 1'b0;
    bus.done_req     = 1'b0;
    bus.line         = 4'b1111;
    bus.enable       = 4'b1111;
    bus.idle_limit   = '0;
    bus.global_limit = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    int m;
    // lim, glim, en, held, stop, exp_step, exp_chan, exp_first, exp_gexp
    vt[0] = '{24'd100, 32'd0,   4'b1111, 4'b0100, 0,  101, 4'b0100, 4'd2, 1'b0};
    vt[1] = '{24'd100, 32'd0,   4'b1111, 4'b1010, 0,  101, 4'b1010, 4'd1, 1'b0};
    vt[2] = '{24'd50,  32'd0,   4'b1111, 4'b1010, 40, 93,  4'b1010, 4'd1, 1'b0};
    vt[3] = '{24'd64,  32'd0,   4'b1111, 4'b0001, 60, 127, 4'b0001, 4'd0, 1'b0};
    vt[4] = '{24'd40,  32'd300, 4'b0110, 4'b1001, 0,  301, 4'b0000, 4'd0, 1'b1};
    vt[5] = '{24'd0,   32'd200, 4'b1111, 4'b1111, 0,  201, 4'b0000, 4'd0, 1'b1};
    vt[6] = '{24'd25,  32'd0,   4'b1111, 4'b1000, 0,  26,  4'b1000, 4'd3, 1'b0};
    vt[7] = '{24'd60,  32'd60,  4'b1111, 4'b0010, 0,  61,  4'b0010, 4'd1, 1'b1};

    bus.start = 1'b0; bus.kick = 1'b0; bus.done_req = 1'b0;
    bus.line = 4'b1111; bus.enable = 4'b1111;
    bus.idle_limit = '0; bus.global_limit = '0;
    #1;
    chk("rst state",          32'(bus.state), 0);
    chk("rst busy",           32'(bus.busy), 0);
    chk("rst done_ack",       32'(bus.done_ack), 0);
    chk("rst timeout",        32'(bus.timeout), 0);
    chk("rst chan_timeout",   32'(bus.chan_timeout), 0);
    chk("rst first_chan",     32'(bus.first_chan), 0);
    chk("rst global_expired", 32'(bus.global_expired), 0);

    // Expiry table: held channels toggle every 20 steps only up to 'stop'.
    for (int v = 0; v < 8; v++) begin
      reset_dut();
      bus.idle_limit   = vt[v].lim;
      bus.global_limit = vt[v].glim;
      bus.enable       = vt[v].en;
      do_start();
      n = 1;
      while (!bus.timeout && n < vt[v].exp_step + 20) begin
        if (n % 20 == 0) begin
          bus.line = bus.line ^ ~vt[v].held;
          if (n <= vt[v].stop) bus.line = bus.line ^ vt[v].held;
        end
        step();
        n++;
      end
      chk($sformatf("vec%0d timeout step", v), 32'(n), 32'(vt[v].exp_step));
      chk($sformatf("vec%0d state", v), 32'(bus.state), 4);
      chk($sformatf("vec%0d busy", v), 32'(bus.busy), 0);
      chk($sformatf("vec%0d chan_timeout", v), 32'(bus.chan_timeout), 32'(vt[v].exp_chan));
      chk($sformatf("vec%0d first_chan", v), 32'(bus.first_chan), 32'(vt[v].exp_first));
      chk($sformatf("vec%0d global_expired", v), 32'(bus.global_expired), 32'(vt[v].exp_gexp));
    end

    // Reset asserted mid-run acts without a clock edge.
    reset_dut();
    bus.idle_limit = 24'd100;
    do_start();
    for (int i = 1; i < 30; i++) begin
      if (i % 5 == 0) bus.line = ~bus.line;
      step();
    end
    chk("midrun busy before reset", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun async state", 32'(bus.state), 0);
    chk("midrun async busy", 32'(bus.busy), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("midrun state after release", 32'(bus.state), 0);
    chk("midrun timeout after release", 32'(bus.timeout), 0);

    // Global timeout with a kick at step 400.
    reset_dut();
    bus.idle_limit   = 24'd100;
    bus.global_limit = 32'd500;
    do_start();
    n = 1;
    while (!bus.timeout && n < 1000) begin
      if (n % 20 == 0) bus.line = ~bus.line;
      bus.kick = (n == 400);
      step();
      n++;
    end
    bus.kick = 1'b0;
    chk("kick timeout step", 32'(n), 901);
    chk("kick global_expired", 32'(bus.global_expired), 1);
    chk("kick chan_timeout", 32'(bus.chan_timeout), 0);
    do_start();
    step();
    chk("start ignored in TIMEOUT", 32'(bus.state), 4);

    // Drain with line 0 toggling after done_req; done_ack 64 after last edge.
    reset_dut();
    bus.idle_limit = 24'd1000;
    do_start();
    n = 1;
    while (n < 10) begin step(); n++; end
    bus.done_req = 1'b1;
    step(); n++;
    chk("drain entry state", 32'(bus.state), 2);
    chk("drain entry busy", 32'(bus.busy), 1);
    while (!bus.done_ack && n < 200) begin
      if (n % 5 == 0 && n <= 40) bus.line[0] = ~bus.line[0];
      step();
      n++;
    end
    chk("drain done step", 32'(n), 107);
    chk("drain done state", 32'(bus.state), 3);
    chk("drain done busy", 32'(bus.busy), 0);

    // Restart from DONE, then drain with no edges at all.
    bus.done_req = 1'b0;
    do_start();
    chk("restart state", 32'(bus.state), 1);
    chk("restart done_ack", 32'(bus.done_ack), 0);
    bus.done_req = 1'b1;
    step();
    m = 1;
    while (!bus.done_ack && m < 200) begin step(); m++; end
    chk("quiet drain step", 32'(m), 65);

    // done_req falling mid-drain returns to RUN.
    bus.done_req = 1'b0;
    do_start();
    bus.done_req = 1'b1;
    step();
    repeat (20) step();
    chk("abort still drain", 32'(bus.state), 2);
    bus.done_req = 1'b0;
    step();
    chk("abort back to RUN", 32'(bus.state), 1);
    repeat (70) step();
    chk("abort stays RUN", 32'(bus.state), 1);
    chk("abort no done_ack", 32'(bus.done_ack), 0);

    // Channel 3 expiry coincides with drain completion; expiry wins.
    reset_dut();
    bus.idle_limit = 24'd74;
    do_start();
    n = 1;
    while (n < 10) begin
      if (n == 5) bus.line[2:0] = ~bus.line[2:0];
      step();
      n++;
    end
    bus.done_req = 1'b1;
    while (n < 74) begin step(); n++; end
    chk("race pre state", 32'(bus.state), 2);
    step();
    chk("race state", 32'(bus.state), 4);
    chk("race done_ack", 32'(bus.done_ack), 0);
    chk("race timeout", 32'(bus.timeout), 1);
    chk("race first_chan", 32'(bus.first_chan), 3);
    chk("race chan_timeout", 32'(bus.chan_timeout), 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_channel_watchdog.md
# multi_channel_watchdog

Parametrised successor to the fixed single-timeout testbench watchdog: supervises CHANNELS serial lines, such as UART tx/rx, plus a global run timer. It manages the test-completion handshake with a drain phase. It sits in the testbench top beside the DUT, and the verification top polls its status to end or abort a run.

## Interface
- CHANNELS, 4, number of supervised serial lines (1..16)
- CNT_W, 24, width of per-channel idle counters and idle_limit
- GLB_W, 32, width of global run counter and global_limit
- DRAIN_CYCLES, 64, consecutive all-quiet cycles required before done_ack
- clk  in  1  sampling clock
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  pulse; arms the watchdog from IDLE or DONE
- kick  in  1  pulse; clears the global counter
- done_req  in  1  level; test requests orderly finish
- line  in  CHANNELS  raw asynchronous serial lines
- enable  in  CHANNELS  per-channel supervision enable
- idle_limit  in  CNT_W  per-channel idle timeout in cycles; 0 disables all channel timeouts
- global_limit  in  GLB_W  global timeout in cycles; 0 disables
- state  out  3  0 IDLE, 1 RUN, 2 DRAIN, 3 DONE, 4 TIMEOUT
- busy  out  1  state is RUN or DRAIN
- done_ack  out  1  high in DONE
- timeout  out  1  high in TIMEOUT
- chan_timeout  out  CHANNELS  sticky per-channel expiry flags
- first_chan  out  4  index of first expired channel
- global_expired  out  1  sticky; the global counter caused TIMEOUT

## Operation
- Each line passes through a 2-flop synchroniser and a third delay flop. Edge = sync2 XOR sync3. The sync flops reset to 1 (serial idle).
- Per-channel counter:
  - Cleared on an edge, when enable[i]=0, or when the state is not RUN/DRAIN.
  - Otherwise it increments, saturating at idle_limit.
- Expiry for channel i: counter == idle_limit-1, no edge on i, enable[i]=1, idle_limit != 0, state RUN or DRAIN. On expiry, set chan_timeout[i].
- Global counter:
  - Runs in RUN and DRAIN only; cleared by kick or start.
  - Expiry when counter == global_limit-1, no kick, global_limit != 0. On expiry, set global_expired.
- State transitions:
  - IDLE or DONE -> RUN on start. Clears all counters, chan_timeout, first_chan and global_expired.
  - RUN -> DRAIN when done_req=1.
  - RUN or DRAIN -> TIMEOUT on any channel expiry or global expiry.
  - DRAIN: a quiet counter counts cycles with no edge on any enabled channel and resets on any such edge. DRAIN -> DONE when quiet counter == DRAIN_CYCLES-1 and the current cycle is quiet.
  - DRAIN -> RUN if done_req falls before DONE. The quiet counter clears.
  - TIMEOUT is terminal; only rst_n leaves it. start is ignored in TIMEOUT, RUN and DRAIN.
- Priority within one cycle:
  - Expiry beats done_req and DRAIN completion.
  - kick beats global expiry.
  - Among simultaneous channel expiries, first_chan takes the lowest index. All of them still set their chan_timeout bits.
- first_chan is written only on the transition into TIMEOUT caused by a channel; otherwise it holds.
- Disabled channels (enable=0) never expire and are ignored by the drain quiet check.
- Changing idle_limit mid-run takes effect immediately. A counter already above a new lower limit expires only after the next saturating compare; the bench avoids this case.

## Timing
- Reset values:
  - state=IDLE; busy, done_ack, timeout, global_expired = 0.
  - chan_timeout=0, first_chan=0, all counters 0.
- Line-to-edge latency: 3 clk from a line transition to the counter clear.
- Channel expiry: chan_timeout[i] and timeout rise exactly idle_limit cycles after the last counter clear, registered.
- Global expiry: timeout rises global_limit cycles after start or the last kick.
- start and done_req take effect on the next rising clk. Outputs are registered and change one cycle after the decision.
- done_ack rises DRAIN_CYCLES cycles after the last edge seen in DRAIN, or after DRAIN entry if no edges occur.
- An rst_n assertion at any time asynchronously forces reset values.

## Test plan
- Reset mid-RUN:
  - Stimulus: CHANNELS=4, start, toggle lines, drop rst_n for 2 cycles mid-run.
  - Response: all outputs at reset values immediately; state=0 after release.
- Channel expiry:
  - Stimulus: idle_limit=100, global_limit=0, enable=4'b1111; toggle lines 0,1,3 every 20 cycles; hold line 2.
  - Response: timeout and chan_timeout=4'b0100 at 100 cycles; first_chan=2.
- Simultaneous expiry:
  - Stimulus: lines 1 and 3 stop on the same cycle; the others keep toggling.
  - Response: chan_timeout=4'b1010, first_chan=1.
- Global timeout and kick:
  - Stimulus: global_limit=500, all channels toggling; kick at cycle 400; then no kick.
  - Response: timeout at cycle 900; global_expired=1, chan_timeout=0.
- Drain handshake:
  - Stimulus: DRAIN_CYCLES=64; assert done_req while line 0 toggles for 30 more cycles.
  - Response: state=DRAIN; done_ack exactly 64 cycles after the last edge.
  - Stimulus: deassert done_req mid-drain instead.
  - Response: state returns to RUN.
- Expiry during drain:
  - Stimulus: in DRAIN, line 3 idle reaches idle_limit on the same cycle the drain would complete.
  - Response: state=TIMEOUT, done_ack=0, first_chan=3.
